xy_store_ctrl: RTL and testbench

- Store sequencer for the X/Y index registers: the read-out direction of the register load path.
- On a start command, captures either the X or Y register value and writes it to data memory through a req/ack handshake.
- A bounded wait raises an error if memory never acknowledges.
- Sits between the X/Y register pair and the data-memory port; the control unit issues it for store-index instructions.

---
 rtl/xy_store_ctrl_pkg.sv | 16 +
 rtl/xy_wait_timer.sv | 29 ++
 rtl/xy_store_ctrl.sv | 101 ++++++++++
 tb/tb_xy_store_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/xy_store_ctrl_pkg.sv
// Shared definitions for the X/Y index register store path.
package xy_store_ctrl_pkg;

  // Width defaults shared with the X/Y register blocks.
  localparam int XY_DATA_W = 16;
  localparam int XY_ADDR_W = 16;

  // Store sequencer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/xy_wait_timer.sv
// Clearable up-counter that flags when TIMEOUT-1 cycles have been counted.
module xy_wait_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

  // Count enabled wait cycles; saturate at terminal count, clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/xy_store_ctrl.sv
// Store sequencer: captures X or Y and writes it to data memory via req/ack,
// with a bounded wait that reports a timeout.
module xy_store_ctrl
  import xy_store_ctrl_pkg::*;
#(
  parameter int DATA_W  = XY_DATA_W,
  parameter int ADDR_W  = XY_ADDR_W,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sel_y,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] x_val,
  input  logic [DATA_W-1:0] y_val,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_q, busy_q, done_q, err_q;
  logic              tmr_clr, tmr_en, tmr_tc;

  xy_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

  // Next-state and capture logic; ack takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = sel_y ? y_val : x_val;
          tmr_clr = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (tmr_tc) begin
          state_d = ST_ERR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured data and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= (state_d == ST_REQ);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERR);
    end
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_xy_store_ctrl.sv
// Directed bench for xy_store_ctrl; outputs sampled on the falling edge.
module tb_xy_store_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sel_y;
  logic [15:0] addr;
  logic [15:0] x_val;
  logic [15:0] y_val;
  logic        mem_ack;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  xy_store_ctrl #(
    .DATA_W (16),
    .ADDR_W (16),
    .TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sel_y    (sel_y),
    .addr     (addr),
    .x_val    (x_val),
    .y_val    (y_val),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %-18s got=0x%0h", tag, got);
    end else begin
      $display("FAIL %-18s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample at the following falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int n;
    // 1: reset held with start asserted
    reset = 1'b1; start = 1'b1; sel_y = 1'b0; addr = 16'h0000;
    x_val = 16'h0000; y_val = 16'h0000; mem_ack = 1'b0;
    #22;
    check("rst_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_wdata", mem_wdata, 16'h0000);
    check("rst_addr", mem_addr, 16'h0000);
    reset = 1'b0; start = 1'b0;
    tick(); tick();
    check("idle_req", mem_req, 0);
    check("idle_busy", busy, 0);

    // 2: store X, ack tied high
    x_val = 16'h0002; y_val = 16'h0001; sel_y = 1'b0; addr = 16'h0040;
    mem_ack = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("t2_req", mem_req, 1);
    check("t2_busy", busy, 1);
    check("t2_wdata", mem_wdata, 16'h0002);
    check("t2_addr", mem_addr, 16'h0040);
    tick();
    check("t2_req_fall", mem_req, 0);
    check("t2_done", done, 1);
    tick();
    check("t2_done_end", done, 0);
    check("t2_busy_end", busy, 0);
    mem_ack = 1'b0;

    // 3: store Y, ack after 3 cycles, inputs disturbed mid-REQ
    sel_y = 1'b1; addr = 16'h0041; start = 1'b1;
    tick(); start = 1'b0;
    check("t3_wdata", mem_wdata, 16'h0001);
    y_val = 16'hFFFF; addr = 16'h0099;
    n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_req) n++;
    end
    check("t3_req_cycles", n, 4);
    check("t3_wdata_frozen", mem_wdata, 16'h0001);
    check("t3_addr_frozen", mem_addr, 16'h0041);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t3_req_fall", mem_req, 0);
    check("t3_done", done, 1);
    tick();
    check("t3_done_once", done, 0);
    check("t3_busy_end", busy, 0);

    // 4: no ack -> timeout after 8 request cycles
    sel_y = 1'b0; x_val = 16'h1234; addr = 16'h0050; start = 1'b1;
    tick(); start = 1'b0;
    n = mem_req ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!mem_req) break;
      n++;
    end
    check("t4_req_cycles", n, 8);
    check("t4_err", err, 1);
    check("t4_done", done, 0);
    tick();
    check("t4_err_end", err, 0);
    check("t4_busy_end", busy, 0);
    check("t4_wdata_kept", mem_wdata, 16'h1234);
    check("t4_addr_kept", mem_addr, 16'h0050);

    // 5: second start during REQ, ack lands on the timeout edge
    x_val = 16'hA5A5; addr = 16'h0060; start = 1'b1;
    tick(); start = 1'b0;
    check("t5_req", mem_req, 1);
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
        start = 1'b1; sel_y = 1'b1; addr = 16'h0077;
      end
      tick();
      start = 1'b0;
    end
    check("t5_addr_kept", mem_addr, 16'h0060);
    check("t5_wdata_kept", mem_wdata, 16'hA5A5);
    check("t5_req_still", mem_req, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t5_done", done, 1);
    check("t5_err", err, 0);
    tick();
    check("t5_done_end", done, 0);
    check("t5_err_end", err, 0);
    tick();
    check("t5_not_queued", busy, 0);

    // 6: reset mid-REQ, then a fresh store
    sel_y = 1'b0; x_val = 16'h0BEE; addr = 16'h0070; start = 1'b1;
    tick(); start = 1'b0;
    check("t6_req", mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_req", mem_req, 0);
    check("t6_async_busy", busy, 0);
    #1 reset = 1'b0;
    tick();
    check("t6_no_done", done, 0);
    check("t6_no_err", err, 0);
    check("t6_idle", busy, 0);
    x_val = 16'h0C0D; addr = 16'h0071; mem_ack = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    check("t6_new_wdata", mem_wdata, 16'h0C0D);
    check("t6_new_addr", mem_addr, 16'h0071);
    tick();
    mem_ack = 1'b0;
    check("t6_new_done", done, 1);
    tick();
    check("t6_new_idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
